// File: rtl/bcd_to_bin.sv
// Six-digit packed BCD to 20-bit binary converter.
// Serial MSD-first multiply-by-ten accumulation, one digit per clock.
module bcd_to_bin (
  input  logic        Sys_CLK,
  input  logic        Sys_RST_N,
  input  logic        Start,
  input  logic [23:0] Data_BCD,
  output logic [19:0] Data_Bin,
  output logic        Busy,
  output logic        Done,
  output logic        Err
);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] sr_q, sr_d;
  logic [19:0] acc_q, acc_d;
  logic [19:0] bin_q, bin_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        inv_q, inv_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [3:0]  nib;
  logic [19:0] acc_nx;
  logic        nib_bad;

  assign nib     = sr_q[23:20];
  assign nib_bad = (nib > 4'd9);
  // Invalid nibbles still accumulate raw; overflow wraps mod 2^20.
  assign acc_nx  = (acc_q << 3) + (acc_q << 1) + {16'd0, nib};

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    inv_d   = inv_q;
    err_d   = err_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          sr_d    = Data_BCD;
          acc_d   = '0;
          cnt_d   = 3'd5;
          inv_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        acc_d = acc_nx;
        sr_d  = sr_q << 4;
        inv_d = inv_q | nib_bad;
        if (cnt_q == 3'd0) begin
          bin_d   = acc_nx;
          err_d   = inv_q | nib_bad;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d  = cnt_q - 3'd1;
          busy_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Sys_CLK) begin
    if (!Sys_RST_N) begin
      state_q <= IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      inv_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      inv_q   <= inv_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Data_Bin = bin_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Err      = err_q;

endmodule
